// File: rtl/lsu_pkg.sv
// Shared types and constants for the two-requester load/store arbiter.
// The LSU_ROUND_ROBIN_EN build macro selects alternating arbitration in lsu_arbiter.
package lsu_pkg;

    localparam int LSU_ADDR_W = 12;
    localparam int LSU_DATA_W = 32;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    localparam logic [11:0] MEM_BASE = 12'h000;
    localparam logic [11:0] MEM_TOP  = 12'h7FF;
    localparam logic [11:0] OUT_BASE = 12'h800;
    localparam logic [11:0] OUT_TOP  = 12'h8FF;
    localparam logic [11:0] IN_BASE  = 12'h900;
    localparam logic [11:0] IN_TOP   = 12'h9FF;

    typedef struct packed {
        logic                  we;
        logic [LSU_ADDR_W-1:0] addr;
        logic [LSU_DATA_W-1:0] wdata;
        logic [3:0]            mask;
        logic                  unsign;
    } lsu_req_t;

    typedef struct packed {
        logic valid;
        logic id;
        logic is_load;
        logic fault;
    } lsu_rsp_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/lsu_access_check.sv
// Combinational fault decode for one request: size/alignment, unmapped
// addresses and stores into the read-only input-peripheral window.
module lsu_access_check
    import lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W
) (
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        mask,
    output logic              fault
);

    localparam logic [ADDR_W-1:0] IN_LO = ADDR_W'(IN_BASE);
    localparam logic [ADDR_W-1:0] IN_HI = ADDR_W'(IN_TOP);

    logic align_fault;
    logic map_fault;
    logic ro_fault;

    always_comb begin
        case (mask)
            MASK_B:  align_fault = 1'b0;
            MASK_H:  align_fault = addr[0];
            MASK_W:  align_fault = |addr[1:0];
            default: align_fault = 1'b1;
        endcase
    end

    // The three windows are contiguous, so anything above the input window is unmapped.
    assign map_fault = (addr > IN_HI);
    assign ro_fault  = we && (addr >= IN_LO) && !map_fault;
    assign fault     = align_fault | map_fault | ro_fault;

endmodule

// File: rtl/lsu_arbiter.sv
// Arbitrates the load/store unit between the core (m0) and the loader (m1).
// Define LSU_ROUND_ROBIN_EN for alternating grants instead of fixed priority.
module lsu_arbiter
    import lsu_pkg::*;
#(
    parameter int ADDR_W     = LSU_ADDR_W,
    parameter int DATA_W     = LSU_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic [3:0]        m0_mask_i,
    input  logic              m0_unsign_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_err_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic [3:0]        m1_mask_i,
    input  logic              m1_unsign_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_err_o,

    output logic              lsu_st_en_o,
    output logic [ADDR_W-1:0] lsu_addr_o,
    output logic [DATA_W-1:0] lsu_st_data_o,
    output logic [3:0]        lsu_mask_o,
    output logic              lsu_unsign_o,
    input  logic [DATA_W-1:0] lsu_ld_data_i
);

    lsu_req_t          req [2];
    logic [1:0]        req_v;
    logic [1:0]        fault;
    logic [1:0]        gnt;
    logic              issue;
    logic              sel;
    logic              issue_ok;
    lsu_req_t          cur;
    lsu_state_t        state_reg, state_next;
    lsu_rsp_t          rsp_reg, rsp_next;
    logic              rsp_live;
    logic [DATA_W-1:0] load_data;

    assign req[0] = '{we: m0_we_i, addr: m0_addr_i, wdata: m0_wdata_i,
                      mask: m0_mask_i, unsign: m0_unsign_i};
    assign req[1] = '{we: m1_we_i, addr: m1_addr_i, wdata: m1_wdata_i,
                      mask: m1_mask_i, unsign: m1_unsign_i};
    assign req_v  = {m1_req_i, m0_req_i};

    for (genvar gi = 0; gi < 2; gi++) begin : g_check
        lsu_access_check #(.ADDR_W(ADDR_W)) u_check (
            .we    (req[gi].we),
            .addr  (req[gi].addr),
            .mask  (req[gi].mask),
            .fault (fault[gi])
        );
    end

`ifdef LSU_ROUND_ROBIN_EN
    logic last_gnt_reg;

    // On a tie the requester that did not win last time gets the LSU.
    always_comb begin
        gnt = 2'b00;
        if (rst_ni) begin
            if (req_v == 2'b11) gnt = last_gnt_reg ? 2'b01 : 2'b10;
            else                gnt = req_v;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   last_gnt_reg <= 1'b1;
        else if (|gnt) last_gnt_reg <= gnt[1];
    end
`else
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic             starved;

    assign starved = (wait_cnt_reg == CNT_W'(STARVE_MAX));

    always_comb begin
        gnt = 2'b00;
        if (rst_ni) begin
            if (req_v[1] && (!req_v[0] || starved)) gnt = 2'b10;
            else if (req_v[0])                      gnt = 2'b01;
        end
    end

    always_comb begin
        wait_cnt_next = '0;
        if (req_v[1] && !gnt[1]) wait_cnt_next = starved ? wait_cnt_reg : wait_cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wait_cnt_reg <= '0;
        else         wait_cnt_reg <= wait_cnt_next;
    end
`endif

    assign issue    = |gnt;
    assign sel      = gnt[1];
    assign cur      = req[sel];
    assign issue_ok = issue & ~fault[sel];

    assign m0_gnt_o      = gnt[0];
    assign m1_gnt_o      = gnt[1];
    assign lsu_st_en_o   = issue_ok & cur.we;
    assign lsu_addr_o    = issue_ok ? cur.addr   : '0;
    assign lsu_st_data_o = issue_ok ? cur.wdata  : '0;
    assign lsu_mask_o    = issue_ok ? cur.mask   : '0;
    assign lsu_unsign_o  = issue_ok & cur.unsign;

    // Only loads and faults need a response; a clean store completes at its grant.
    always_comb begin
        state_next = ST_IDLE;
        rsp_next   = '0;
        if (issue && (fault[sel] || !cur.we)) begin
            state_next = ST_RESP;
            rsp_next   = '{valid: 1'b1, id: sel, is_load: ~cur.we, fault: fault[sel]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
            rsp_reg   <= '0;
        end else begin
            state_reg <= state_next;
            rsp_reg   <= rsp_next;
        end
    end

    assign rsp_live  = (state_reg == ST_RESP) && rsp_reg.valid;
    assign load_data = (rsp_reg.is_load && !rsp_reg.fault) ? lsu_ld_data_i : '0;

    assign m0_rvalid_o = rsp_live && !rsp_reg.id;
    assign m1_rvalid_o = rsp_live &&  rsp_reg.id;
    assign m0_rdata_o  = m0_rvalid_o ? load_data : '0;
    assign m1_rdata_o  = m1_rvalid_o ? load_data : '0;
    assign m0_err_o    = m0_rvalid_o && rsp_reg.fault;
    assign m1_err_o    = m1_rvalid_o && rsp_reg.fault;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_lsu_arbiter;

    localparam int STARVE = 4;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    logic        req_d   [2];
    logic        we_d    [2];
    logic [11:0] addr_d  [2];
    logic [31:0] wdata_d [2];
    logic [3:0]  mask_d  [2];
    logic        uns_d   [2];

    logic        m0_gnt, m1_gnt, m0_rv, m1_rv, m0_err, m1_err;
    logic [31:0] m0_rd, m1_rd;
    logic        st_en, l_uns;
    logic [11:0] l_addr;
    logic [31:0] l_data;
    logic [3:0]  l_mask;
    logic [31:0] ld_data = 32'h0;

    lsu_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_MAX(STARVE)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(req_d[0]), .m0_we_i(we_d[0]), .m0_addr_i(addr_d[0]), .m0_wdata_i(wdata_d[0]),
        .m0_mask_i(mask_d[0]), .m0_unsign_i(uns_d[0]),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rv), .m0_rdata_o(m0_rd), .m0_err_o(m0_err),
        .m1_req_i(req_d[1]), .m1_we_i(we_d[1]), .m1_addr_i(addr_d[1]), .m1_wdata_i(wdata_d[1]),
        .m1_mask_i(mask_d[1]), .m1_unsign_i(uns_d[1]),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rv), .m1_rdata_o(m1_rd), .m1_err_o(m1_err),
        .lsu_st_en_o(st_en), .lsu_addr_o(l_addr), .lsu_st_data_o(l_data),
        .lsu_mask_o(l_mask), .lsu_unsign_o(l_uns), .lsu_ld_data_i(ld_data)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte memories: mem_m is the model's view, mem_e backs the LSU emulation.
    bit   [7:0]  mem_m [4096];
    bit   [7:0]  mem_e [4096];
    logic [31:0] io_sw = 32'h98765432;

    function automatic int nbytes(input logic [3:0] m);
        return (m == 4'b0001) ? 1 : (m == 4'b0011) ? 2 : 4;
    endfunction

    function automatic logic [31:0] rd(input bit env, input logic [11:0] a, input logic [3:0] m, input logic u);
        logic [31:0] v;
        int n, idx;
        n = nbytes(m);
        v = '0;
        for (int k = 0; k < n; k++) begin
            idx = (int'(a) + k) % 4096;
            if (idx >= 'h900 && idx <= 'h9FF) v[8*k +: 8] = io_sw[8*(idx % 4) +: 8];
            else                              v[8*k +: 8] = env ? mem_e[idx] : mem_m[idx];
        end
        if (!u && n < 4 && v[8*n-1])
            for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic wr(input bit env, input logic [11:0] a, input logic [3:0] m, input logic [31:0] d);
        int idx;
        for (int k = 0; k < nbytes(m); k++) begin
            idx = (int'(a) + k) % 4096;
            if (env) mem_e[idx] = d[8*k +: 8];
            else     mem_m[idx] = d[8*k +: 8];
        end
    endtask

    function automatic bit is_fault(input logic we, input logic [11:0] a, input logic [3:0] m);
        bit f;
        if (m == 4'b0001)      f = 1'b0;
        else if (m == 4'b0011) f = a[0];
        else if (m == 4'b1111) f = (a[1:0] != 2'b00);
        else                   f = 1'b1;
        if (a > 12'h9FF) f = 1'b1;
        if (we && a >= 12'h900 && a <= 12'h9FF) f = 1'b1;
        return f;
    endfunction

    // Model state: pending response, m1 waiting time, last winner.
    bit          m_pend, m_pid, m_perr;
    logic [31:0] m_prd;
    int          m_wait;
    bit          m_last = 1'b1;
    bit          gnt_prev  [2];
    bit          dgnt_prev [2];
    bit          req_prev  [2];
    bit          prev_ok = 1'b0;
    logic [31:0] env_next = 32'h0;

    int          w;
    bit          f;
    bit          e_gnt [2];
    bit          e_rv  [2];
    bit          e_er  [2];
    logic [31:0] e_rd  [2];

    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
                chk("rst_rvalid", {30'd0, m1_rv, m0_rv}, 32'd0);
                chk("rst_lsu", {st_en, l_uns, l_mask, l_addr}, 32'd0);
                chk("rst_rdata", m0_rd | m1_rd | l_data, 32'd0);
                m_pend = 0; m_wait = 0; m_last = 1'b1; prev_ok = 1'b0;
                gnt_prev[0] = 0; gnt_prev[1] = 0;
                env_next = $urandom;
            end else begin
                for (int i = 0; i < 2; i++)
                    if (prev_ok && req_prev[i] && !dgnt_prev[i])
                        assert (req_d[i] === 1'b1) else $error("protocol: m%0d dropped req before gnt", i);

                w = -1;
`ifdef LSU_ROUND_ROBIN_EN
                if (req_d[0] && req_d[1]) w = m_last ? 0 : 1;
                else if (req_d[0])        w = 0;
                else if (req_d[1])        w = 1;
`else
                if (req_d[1] && (!req_d[0] || m_wait >= STARVE)) w = 1;
                else if (req_d[0])                               w = 0;
`endif
                f = (w >= 0) ? is_fault(we_d[w], addr_d[w], mask_d[w]) : 1'b0;
                for (int i = 0; i < 2; i++) begin
                    e_gnt[i] = (w == i);
                    e_rv[i]  = m_pend && (m_pid == i[0]);
                    e_rd[i]  = e_rv[i] ? m_prd : 32'h0;
                    e_er[i]  = e_rv[i] && m_perr;
                end

                chk("m0_gnt", m0_gnt, e_gnt[0]);
                chk("m1_gnt", m1_gnt, e_gnt[1]);
                chk("m0_rvalid", m0_rv, e_rv[0]);
                chk("m1_rvalid", m1_rv, e_rv[1]);
                chk("m0_rdata", m0_rd, e_rd[0]);
                chk("m1_rdata", m1_rd, e_rd[1]);
                chk("m0_err", m0_err, e_er[0]);
                chk("m1_err", m1_err, e_er[1]);
                if (w >= 0 && !f) begin
                    chk("lsu_st_en", st_en, we_d[w]);
                    chk("lsu_addr", l_addr, addr_d[w]);
                    chk("lsu_st_data", l_data, wdata_d[w]);
                    chk("lsu_mask", l_mask, mask_d[w]);
                    chk("lsu_unsign", l_uns, uns_d[w]);
                end else begin
                    chk("lsu_idle", {st_en, l_uns, l_mask, l_addr}, 32'd0);
                    chk("lsu_idle_data", l_data, 32'd0);
                end

`ifndef LSU_ROUND_ROBIN_EN
                if (req_d[1] && w != 1) m_wait = (m_wait < STARVE) ? m_wait + 1 : STARVE;
                else                    m_wait = 0;
`endif
                if (w >= 0) m_last = (w == 1);
                m_pend = 0; m_perr = 0; m_prd = 32'h0;
                if (w >= 0) begin
                    if (f || !we_d[w]) begin
                        m_pend = 1; m_pid = (w == 1); m_perr = f;
                        m_prd  = f ? 32'h0 : rd(0, addr_d[w], mask_d[w], uns_d[w]);
                    end else begin
                        wr(0, addr_d[w], mask_d[w], wdata_d[w]);
                    end
                end
                for (int i = 0; i < 2; i++) begin
                    gnt_prev[i]  = e_gnt[i];
                    dgnt_prev[i] = (i == 0) ? m0_gnt : m1_gnt;
                    req_prev[i]  = req_d[i];
                end
                prev_ok = 1'b1;

                // LSU emulation: loads return data next cycle, otherwise junk.
                if ((m0_gnt || m1_gnt) && st_en) wr(1, l_addr, l_mask, l_data);
                if ((m0_gnt || m1_gnt) && !st_en) env_next = rd(1, l_addr, l_mask, l_uns);
                else                              env_next = $urandom;
            end
            @(posedge clk_i);
            #1 ld_data = env_next;
        end
    end

    task automatic issue(input int id, input bit we, input logic [11:0] a, input logic [31:0] d,
                         input logic [3:0] m, input bit u, output bit rv, output logic [31:0] rdat,
                         output bit er, output logic [11:0] ia, output bit ist);
        int t;
        @(posedge clk_i); #1;
        req_d[id] = 1'b1; we_d[id] = we; addr_d[id] = a; wdata_d[id] = d; mask_d[id] = m; uns_d[id] = u;
        t = 0;
        @(negedge clk_i);
        while (((id == 0) ? m0_gnt : m1_gnt) !== 1'b1 && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        chk("gnt_wait", (t < 20), 32'd1);
        ia = l_addr; ist = st_en;
        @(posedge clk_i); #1;
        req_d[id] = 1'b0;
        @(negedge clk_i);
        rv   = (id == 0) ? m0_rv  : m1_rv;
        rdat = (id == 0) ? m0_rd  : m1_rd;
        er   = (id == 0) ? m0_err : m1_err;
        $display("txn m%0d we=%0b addr=%h mask=%b -> rvalid=%0b rdata=%h err=%0b", id, we, a, m, rv, rdat, er);
    endtask

    bit          rv, er, ist, g0, g1, drain;
    logic [31:0] rdat;
    logic [11:0] ia;
    int          seq [5];
    int          t;

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_d[i] = 0; we_d[i] = 0; addr_d[i] = 0; wdata_d[i] = 0; mask_d[i] = 0; uns_d[i] = 0;
        end
        drain = 0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        issue(0, 1, 12'h004, 32'h12348678, 4'b1111, 0, rv, rdat, er, ia, ist);
        chk("st_no_rvalid", rv, 0);
        chk("st_en_issue", ist, 1);
        issue(1, 0, 12'h004, 32'h0, 4'b0001, 0, rv, rdat, er, ia, ist);
        chk("ldb_rvalid", rv, 1);
        chk("ldb_data", rdat, 32'h00000078);
        issue(1, 0, 12'h004, 32'h0, 4'b0011, 0, rv, rdat, er, ia, ist);
        chk("ldh_data", rdat, 32'hFFFF8678);
        issue(1, 0, 12'h004, 32'h0, 4'b0011, 1, rv, rdat, er, ia, ist);
        chk("ldhu_data", rdat, 32'h00008678);

        // Both request together, m0 held continuously.
        @(posedge clk_i); #1;
        we_d[0] = 0; addr_d[0] = 12'h004; mask_d[0] = 4'b1111; uns_d[0] = 0; req_d[0] = 1;
        we_d[1] = 0; addr_d[1] = 12'h008; mask_d[1] = 4'b1111; uns_d[1] = 0; req_d[1] = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            g0 = m0_gnt; g1 = m1_gnt;
            seq[c] = g1 ? 1 : (g0 ? 0 : 9);
            @(posedge clk_i); #1;
            if (g1) req_d[1] = 0;
            if (g0 && c == 4) req_d[0] = 0;
        end
        t = 0;
        while (req_d[0] && t < 10) begin
            @(negedge clk_i);
            g0 = m0_gnt;
            @(posedge clk_i); #1;
            if (g0) req_d[0] = 0;
            t++;
        end
        for (int c = 0; c < 5; c++) begin
`ifdef LSU_ROUND_ROBIN_EN
            chk($sformatf("arb_seq%0d", c), seq[c], (c == 1) ? 1 : 0);
`else
            chk($sformatf("arb_seq%0d", c), seq[c], (c == 4) ? 1 : 0);
`endif
        end
        $display("txn arbitration sequence %0d %0d %0d %0d %0d", seq[0], seq[1], seq[2], seq[3], seq[4]);

        issue(0, 0, 12'h002, 32'h0, 4'b1111, 0, rv, rdat, er, ia, ist);
        chk("misal_lsu_addr", ia, 0);
        chk("misal_st_en", ist, 0);
        chk("misal_rvalid", rv, 1);
        chk("misal_err", er, 1);
        chk("misal_rdata", rdat, 0);
        issue(1, 1, 12'h900, 32'h0000DEAD, 4'b1111, 0, rv, rdat, er, ia, ist);
        chk("st_in_err", {rv, er}, 2'b11);
        issue(1, 0, 12'hA00, 32'h0, 4'b1111, 0, rv, rdat, er, ia, ist);
        chk("ld_unmap_err", {rv, er}, 2'b11);
        issue(1, 0, 12'h900, 32'h0, 4'b0011, 0, rv, rdat, er, ia, ist);
        chk("ld_in_err", er, 0);
        chk("ld_in_data", rdat, 32'h00005432);

        issue(0, 1, 12'h800, 32'hCAFEF00D, 4'b1111, 0, rv, rdat, er, ia, ist);
        @(posedge clk_i); #1;
        we_d[0] = 0; addr_d[0] = 12'h800; mask_d[0] = 4'b1111; uns_d[0] = 0; req_d[0] = 1;
        @(negedge clk_i);
        chk("b2b_gnt_a", m0_gnt, 1);
        @(posedge clk_i); #1;
        addr_d[0] = 12'h004;
        @(negedge clk_i);
        chk("b2b_gnt_b", m0_gnt, 1);
        chk("b2b_rv_a", m0_rv, 1);
        chk("b2b_data_a", m0_rd, 32'hCAFEF00D);
        @(posedge clk_i); #1;
        req_d[0] = 0;
        @(negedge clk_i);
        chk("b2b_rv_b", m0_rv, 1);
        chk("b2b_data_b", m0_rd, 32'h12348678);
        $display("txn back-to-back loads done");

        // Reset right after a load issue drops its response.
        @(posedge clk_i); #1;
        we_d[0] = 0; addr_d[0] = 12'h004; mask_d[0] = 4'b1111; req_d[0] = 1;
        @(negedge clk_i);
        chk("rst_load_gnt", m0_gnt, 1);
        @(posedge clk_i); #1;
        req_d[0] = 0;
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("rst_drop_rv", m0_rv, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_rv", m0_rv, 0);
        issue(0, 0, 12'h004, 32'h0, 4'b1111, 0, rv, rdat, er, ia, ist);
        chk("post_rst_data", rdat, 32'h12348678);

        // Random traffic; requesters hold payload until granted.
        for (int c = 0; c < 3000 + 60; c++) begin
            @(posedge clk_i); #1;
            if (c == 3000) drain = 1;
            for (int i = 0; i < 2; i++) begin
                if (!req_d[i] || gnt_prev[i]) begin
                    if (drain) req_d[i] = 0;
                    else begin
                        req_d[i] = ($urandom_range(0, 3) != 0);
                        we_d[i]  = ($urandom_range(0, 2) == 0);
                        case ($urandom_range(0, 5))
                            0, 1, 2: addr_d[i] = 12'($urandom_range(0, 63));
                            3:       addr_d[i] = 12'h800 + 12'($urandom_range(0, 15));
                            4:       addr_d[i] = 12'h900 + 12'($urandom_range(0, 15));
                            default: addr_d[i] = 12'($urandom);
                        endcase
                        if ($urandom_range(0, 1) == 1) addr_d[i][1:0] = 2'b00;
                        case ($urandom_range(0, 4))
                            0:       mask_d[i] = 4'b0001;
                            1:       mask_d[i] = 4'b0011;
                            2, 3:    mask_d[i] = 4'b1111;
                            default: mask_d[i] = 4'($urandom);
                        endcase
                        wdata_d[i] = $urandom;
                        uns_d[i]   = 1'($urandom);
                    end
                end
            end
        end
        chk("drain_idle", {30'd0, req_d[1], req_d[0]}, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got running, expected finished");
        $fatal(1, "watchdog");
    end

endmodule
